mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the pipeline's single-ported unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage). It sits between the stages and the memory model inside `top`. It serialises accesses through a small FSM and gives data priority, with an anti-starvation limit for fetch. It returns per-port acknowledges; the hazard logic stalls a stage while that stage's `*_req` is high and its `*_ack` is low.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_RUN`, 4, max consecutive data grants while fetch is waiting (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  fetch access complete this cycle
- `if_rdata`  out  DATA_W  fetch data, valid while `if_ack`
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = write
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_be`  in  DATA_W/8  byte enables (writes)
- `d_ack`  out  1  data access complete this cycle
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`

## Operation
- FSM states: IDLE, SERVE_IF, SERVE_D.
- **IDLE**
  - If `d_req` and not (`if_req` and `run_cnt == MAX_D_RUN`): grant data; next state is SERVE_D.
  - Else if `if_req`: grant fetch; next state is SERVE_IF.
  - Else: stay in IDLE.
- **Grant edge**
  - Latch the winner's address, `we` (forced 0 for fetch), `wdata` and `be` into the `mem_*` output registers.
  - The `mem_*` outputs stay constant for the whole SERVE state.
- **SERVE_x**
  - `mem_req` is 1.
  - When `mem_ready` = 1: `x_ack` = 1 combinationally in that same cycle.
  - `x_rdata` = `mem_rdata` (pass-through) while `x_ack` is high.
  - At the next edge the state returns to IDLE and `mem_req`/`mem_we` clear.
- **Outputs outside a completing access**
  - `if_rdata`/`d_rdata` are 0 when their ack is low.
  - Acks are never asserted outside the matching SERVE state.
- **`run_cnt`** (counter, 0..MAX_D_RUN, saturating)
  - On a data grant with `if_req` high: `run_cnt` += 1 (saturate).
  - On a data grant with `if_req` low: `run_cnt` = 0.
  - On a fetch grant: `run_cnt` = 0.
- **Ignored inputs**
  - `mem_ready` in IDLE is ignored.
  - Requests are not sampled in SERVE states.
  - The arbiter does not check a requester dropping `req` mid-access (protocol violation). The access completes and the ack pulses.
- **Reset** (`rst` low, any time, including mid-access)
  - State = IDLE, `run_cnt` = 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - `if_ack`, `d_ack` = 0 and `*_rdata` = 0.
  - An in-flight access is abandoned with no ack.
  - The first grant is possible on the first rising edge after `rst` goes high.

## Timing
- Request seen high in IDLE at cycle N: `mem_req` = 1 from cycle N+1.
- Ack in the cycle `mem_ready` is first high, earliest N+1, so minimum latency is 1 cycle.
- IDLE lasts at least one cycle between accesses: peak throughput is one access per 2 cycles.
- The requester updates `req`/`addr` on the edge ending its ack cycle. The arbiter samples again in the following IDLE cycle, so there is no double grant.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless `run_cnt == MAX_D_RUN`.
- Under continuous contention: exactly MAX_D_RUN data accesses, then one fetch, repeating.
- All registered outputs change only on rising `clk` or asynchronously on falling `rst`.

## Test plan
- **Reset values:** hold `rst` = 0 with all inputs toggling → all outputs 0. Release, drive `if_req`, `if_addr` = 0x10, and assert `mem_ready` one cycle after `mem_req` rises → `mem_addr` = 0x10 and `mem_we` = 0 from the grant edge; `if_ack` is one cycle, with `if_rdata` = `mem_rdata` = 0xDEADBEEF.
- **Write with wait states:** `d_req`, `d_we` = 1, `d_addr` = 0x200, `d_wdata` = 0x12345678, `d_be` = 0xF; `mem_ready` delayed 3 cycles → `mem_*` stable for 3 cycles and `d_ack` only in the `mem_ready` cycle. Return to IDLE for 1 cycle.
- **Anti-starvation:** `if_req` and `d_req` held high continuously with `mem_ready` = 1 every SERVE cycle, MAX_D_RUN = 4 → grant order D,D,D,D,IF,D,D,D,D,IF. `if_ack` appears every 10th cycle.
- **Streak clear:** 3 data grants with `if_req` low, then assert `if_req` with `d_req` high → 4 more data grants before the fetch grant, because `run_cnt` restarted.
- **Reset mid-access:** drop `rst` while in SERVE_D with `mem_req` = 1 → `mem_req`/`d_ack` go to 0 immediately (asynchronously). After release with `d_req` still high, a fresh grant occurs with no ack from the aborted access.
- **Ignored `mem_ready`:** pulse `mem_ready` in IDLE with no requests → no ack and state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch and data.
// Data has priority; fetch wins after MAX_D_RUN back-to-back data grants while it waits.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_D_RUN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_RUN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Data yields only when fetch is waiting and the data streak is exhausted.
                if (d_req && !(if_req && run_cnt_q == MAX_CNT)) begin
                    state_d     = SERVE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    if (!if_req)
                        run_cnt_d = '0;
                    else if (run_cnt_q != MAX_CNT)
                        run_cnt_d = run_cnt_q + 1'b1;
                end else if (if_req) begin
                    state_d     = SERVE_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    run_cnt_d   = '0;
                end
            end
            SERVE_IF: begin
                if (mem_ready) begin
                    if_ack    = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    d_ack     = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata    = if_ack ? mem_rdata : '0;
    assign d_rdata     = d_ack ? mem_rdata : '0;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requesters, a latency-programmable memory responder,
// and an ack monitor that pops expected accesses in grant order.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_ack;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [BW-1:0] d_be;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } d_txn_t;

    d_txn_t        d_pend[$];
    logic [AW-1:0] i_pend[$];
    logic [AW+1:0] exp_q[$];   // {is_data, we, addr} in expected grant order
    int            if_ack_cyc[$];
    logic [AW+1:0] e;
    bit            drv_en = 0, resp_en = 0, mon_en = 0, d_done = 0, i_done = 0;
    int            lat = 1;
    int            scnt = 0;
    int            n_checks = 0, n_pass = 0;

    function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // driver tasks
    task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be);
        d_txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.be = be;
        d_pend.push_back(t);
    endtask

    task automatic exp_d(input logic we, input logic [AW-1:0] a);
        exp_q.push_back({1'b1, we, a});
    endtask

    task automatic exp_i(input logic [AW-1:0] a);
        exp_q.push_back({1'b0, 1'b0, a});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((d_pend.size() != 0 || i_pend.size() != 0 || exp_q.size() != 0 || mem_req)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_mem_req(input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_timeout", mem_req, 1);
    endtask

    // requesters: advance to the next queued access on the edge after their ack
    always @(posedge clk) begin
        #1;
        if (drv_en) begin
            if (d_done) begin
                d_done = 0;
                if (d_pend.size() != 0) void'(d_pend.pop_front());
            end
            if (i_done) begin
                i_done = 0;
                if (i_pend.size() != 0) void'(i_pend.pop_front());
            end
            if (d_pend.size() != 0) begin
                d_req = 1'b1;
                {d_we, d_addr, d_wdata, d_be} = d_pend[0];
            end else begin
                d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
            end
            if (i_pend.size() != 0) begin
                if_req = 1'b1; if_addr = i_pend[0];
            end else begin
                if_req = 1'b0; if_addr = '0;
            end
        end
    end

    // memory responder: mem_ready in the lat-th cycle of each access, noise otherwise
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            if (!rst || !mem_req) begin
                scnt = 0; mem_ready = 1'b0; mem_rdata = '0;
            end else begin
                scnt++;
                if (scnt == lat) begin
                    mem_ready = 1'b1; mem_rdata = rdata_fn(mem_addr);
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom;
                end
            end
        end
    end

    // scoreboard: pop on every ack
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {if_ack, d_ack}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", {if_ack, d_ack}, e[AW+1] ? 2'b01 : 2'b10);
                    check("ack_we", mem_we, e[AW]);
                    check("ack_addr", mem_addr, e[AW-1:0]);
                    check("ack_rdata", if_ack ? if_rdata : d_rdata, rdata_fn(e[AW-1:0]));
                end
                if (d_ack) d_done = 1;
                if (if_ack) begin
                    i_done = 1;
                    if_ack_cyc.push_back(cyc);
                end
            end
            if (!if_ack) check("if_rdata_gate", if_rdata, 0);
            if (!d_ack)  check("d_rdata_gate", d_rdata, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 0; mem_rdata = '0;

        // reset holds every output at zero whatever the inputs do
        repeat (6) begin
            @(posedge clk);
            #2;
            if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
            d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
            mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            @(negedge clk);
            check("rst_ctrl", {if_ack, d_ack, mem_req, mem_we, dbg_state}, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_wdata_be", {mem_wdata, mem_be}, 0);
            check("rst_rdata", {if_rdata, d_rdata}, 0);
        end

        // first fetch granted on the first edge after release
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 0; mem_rdata = '0;
        lat = 2;
        i_pend.push_back(32'h10);
        exp_i(32'h10);
        if_req = 1'b1; if_addr = 32'h10;
        drv_en = 1; resp_en = 1; mon_en = 1;
        rst = 1'b1;
        @(negedge clk);
        check("fetch_grant_req", {mem_req, mem_we, if_ack}, 3'b100);
        check("fetch_grant_addr", mem_addr, 32'h10);
        check("fetch_grant_state", dbg_state, 2'd1);
        @(negedge clk);
        check("fetch_ack", if_ack, 1);
        @(negedge clk);
        check("fetch_done", {mem_req, if_ack, dbg_state}, 0);
        drain(20);

        // write with wait states: mem_* stable, ack only in the ready cycle
        lat = 4;
        push_d(1'b1, 32'h200, 32'h1234_5678, 4'hF);
        exp_d(1'b1, 32'h200);
        wait_mem_req(10);
        for (int k = 0; k < 3; k++) begin
            check("wr_hold_ctrl", {mem_req, mem_we, d_ack}, 3'b110);
            check("wr_hold_addr", mem_addr, 32'h200);
            check("wr_hold_data", {mem_wdata, mem_be}, {32'h1234_5678, 4'hF});
            @(negedge clk);
        end
        check("wr_ack", d_ack, 1);
        @(negedge clk);
        check("wr_idle", {mem_req, mem_we, d_ack, dbg_state}, 0);
        drain(20);

        // continuous contention: D,D,D,D,IF,D,D,D,D,IF
        lat = 1;
        if_ack_cyc.delete();
        for (int j = 0; j < 8; j++) push_d(1'(j), 32'h300 + 32'(4 * j), $urandom, 4'hF);
        i_pend.push_back(32'h400);
        i_pend.push_back(32'h404);
        for (int j = 0; j < 4; j++) exp_d(1'(j), 32'h300 + 32'(4 * j));
        exp_i(32'h400);
        for (int j = 4; j < 8; j++) exp_d(1'(j), 32'h300 + 32'(4 * j));
        exp_i(32'h404);
        drain(100);
        check("starve_if_acks", if_ack_cyc.size(), 2);
        if (if_ack_cyc.size() == 2)
            check("starve_period", if_ack_cyc[1] - if_ack_cyc[0], 10);

        // streak restarts after data grants with fetch idle
        for (int j = 0; j < 3; j++) begin
            push_d(1'b0, 32'h500 + 32'(4 * j), '0, 4'h0);
            exp_d(1'b0, 32'h500 + 32'(4 * j));
        end
        drain(50);
        for (int j = 0; j < 5; j++) push_d(1'b1, 32'h600 + 32'(4 * j), $urandom, 4'h5);
        i_pend.push_back(32'h700);
        for (int j = 0; j < 4; j++) exp_d(1'b1, 32'h600 + 32'(4 * j));
        exp_i(32'h700);
        exp_d(1'b1, 32'h610);
        drain(100);

        // reset mid-access: immediate clear, abandoned access, fresh grant afterwards
        lat = 8;
        push_d(1'b1, 32'h800, 32'hCAFE_F00D, 4'h3);
        exp_d(1'b1, 32'h800);
        wait_mem_req(10);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_ctrl", {mem_req, mem_we, d_ack, dbg_state}, 0);
        check("arst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_mem_req(10);
        check("rerun_addr", mem_addr, 32'h800);
        drain(50);

        // mem_ready in IDLE is ignored
        resp_en = 0;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", {if_ack, d_ack, mem_req, dbg_state}, 0);
        end
        mem_ready = 1'b0; mem_rdata = '0;
        resp_en = 1;
        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
